dram_req_arbiter: RTL

Request arbiter and refresh scheduler between the board-level user requesters (write and read command paths driven from the buttons and switches) and the single-command DDR3 command sequencer inside the top-level memory controller. It owns the only path into the sequencer. It serialises write, read and periodic auto-refresh operations, and returns write acknowledges and read data to the requesters.

---
 rtl/dram_pkg.sv | 28 ++
 rtl/dram_refresh_timer.sv | 54 +++++
 rtl/dram_req_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared encodings for the DRAM request arbiter: command opcodes, arbiter
// FSM states, requester identity and DDR3 address field widths.
package dram_pkg;

    localparam int BA_W  = 3;
    localparam int ROW_W = 15;
    localparam int COL_W = 10;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_WR  = 2'd1,
        OP_RD  = 2'd2,
        OP_REF = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        USER_WR = 1'b0,
        USER_RD = 1'b1
    } user_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter plus the saturating count of refreshes owed and
// a sticky error flag for a refresh tick that could not be recorded.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFI_CYCLES  = 780,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       sysclk,
    input  logic       RESET_SM_n,
    input  logic       init_done,
    input  logic       ref_done,
    output logic [3:0] ref_owed,
    output logic       ref_err
);

    localparam int TMR_W = (REFI_CYCLES > 2) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFI_CYCLES - 1);
    localparam logic [3:0] OWED_MAX = 4'(MAX_POSTPONE);

    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_owed;
    logic             r_err;
    logic             w_tick;
    logic             w_at_max;

    assign w_tick   = init_done && (r_timer == '0);
    assign w_at_max = (r_owed == OWED_MAX);

    // A tick and a refresh completion in the same cycle cancel out.
    always_ff @(posedge sysclk or negedge RESET_SM_n) begin
        if (!RESET_SM_n) begin
            r_timer <= TMR_RELOAD;
            r_owed  <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            if (init_done) begin
                r_timer <= w_tick ? TMR_RELOAD : r_timer - 1'b1;
            end
            if (w_tick && w_at_max) begin
                r_err <= 1'b1;
            end
            if (w_tick && !ref_done && !w_at_max) begin
                r_owed <= r_owed + 4'd1;
            end else if (!w_tick && ref_done && (r_owed != 4'd0)) begin
                r_owed <= r_owed - 4'd1;
            end
        end
    end

    assign ref_owed = r_owed;
    assign ref_err  = r_err;

endmodule

// File: rtl/dram_req_arbiter.sv
// Arbiter serialising user writes, user reads and auto-refresh into the DDR3
// command sequencer. REFRESH_POSTPONE_EN lets refresh yield to user traffic.
module dram_req_arbiter
    import dram_pkg::*;
#(
    parameter int ADDR_W       = BA_W + ROW_W + COL_W,
    parameter int DATA_W       = 8,
    parameter int REFI_CYCLES  = 780,
    parameter int MAX_POSTPONE = 8
) (
    input  logic              sysclk,
    input  logic              RESET_SM_n,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_ready,
    input  logic              rsp_done,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic [3:0]        ref_owed,
    output logic              ref_err
);

    arb_state_t        r_state;
    cmd_op_t           r_op;
    user_t             r_last;
    logic              r_cmd_valid;
    cmd_op_t           r_cmd_op;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic [3:0]        w_ref_owed;
    logic              w_ref_err;
    logic              w_ref_done;
    logic              w_pick_ref;
    logic              w_pick_wr;

    assign w_ref_done = (r_state == ST_WAIT) && rsp_done && (r_op == OP_REF);

    dram_refresh_timer #(
        .REFI_CYCLES (REFI_CYCLES),
        .MAX_POSTPONE(MAX_POSTPONE)
    ) u_refresh_timer (
        .sysclk    (sysclk),
        .RESET_SM_n(RESET_SM_n),
        .init_done (init_done),
        .ref_done  (w_ref_done),
        .ref_owed  (w_ref_owed),
        .ref_err   (w_ref_err)
    );

`ifdef REFRESH_POSTPONE_EN
    assign w_pick_ref = (w_ref_owed != 4'd0) &&
                        (!(wr_req || rd_req) || (w_ref_owed == 4'(MAX_POSTPONE)));
`else
    assign w_pick_ref = (w_ref_owed != 4'd0);
`endif

    // On a tie the requester not served last wins.
    assign w_pick_wr = wr_req && (!rd_req || (r_last == USER_RD));

    always_ff @(posedge sysclk or negedge RESET_SM_n) begin
        if (!RESET_SM_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_last      <= USER_RD;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NOP;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (init_done && (w_pick_ref || wr_req || rd_req)) begin
                        r_state     <= ST_ISSUE;
                        r_cmd_valid <= 1'b1;
                        if (w_pick_ref) begin
                            r_op        <= OP_REF;
                            r_cmd_op    <= OP_REF;
                            r_cmd_addr  <= '0;
                            r_cmd_wdata <= '0;
                        end else if (w_pick_wr) begin
                            r_op        <= OP_WR;
                            r_cmd_op    <= OP_WR;
                            r_cmd_addr  <= wr_addr;
                            r_cmd_wdata <= wr_data;
                            r_last      <= USER_WR;
                        end else begin
                            r_op        <= OP_RD;
                            r_cmd_op    <= OP_RD;
                            r_cmd_addr  <= rd_addr;
                            r_cmd_wdata <= '0;
                            r_last      <= USER_RD;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= ST_WAIT;
                        r_cmd_valid <= 1'b0;
                        r_cmd_op    <= OP_NOP;
                        r_cmd_addr  <= '0;
                        r_cmd_wdata <= '0;
                    end
                end
                ST_WAIT: begin
                    if (rsp_done) begin
                        r_state <= ST_ACK;
                        if (r_op == OP_RD) begin
                            r_rd_data  <= rsp_rdata;
                            r_rd_valid <= 1'b1;
                        end
                        if (r_op == OP_WR) begin
                            r_wr_ack <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_wdata = r_cmd_wdata;
    assign wr_ack    = r_wr_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign ref_owed  = w_ref_owed;
    assign ref_err   = w_ref_err;

endmodule
